// File: rtl/upscaler_pkg.sv
// rtl/upscaler_pkg.sv - shared pixel type and sequencer state encoding for the upscaler
package upscaler_pkg;

    localparam int PIXEL_W = 24;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2,
        S_GAP  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/line_buffer_sp.sv
// rtl/line_buffer_sp.sv - single-port row buffer, synchronous write, registered 1-cycle read
module line_buffer_sp
    import upscaler_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  pixel_t            wdata,
    output pixel_t            rdata
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Only the read register is reset so the output is never X; it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/upscale_sequencer.sv
// rtl/upscale_sequencer.sv - buffers one input row and replays it SCALE x SCALE as a nearest-neighbour stream
module upscale_sequencer
    import upscaler_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 72,
    parameter int SCALE = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  pixel_t s_pixel,
    input  logic   s_valid,
    output logic   s_ready,
    output pixel_t m_pixel,
    output logic   m_valid,
    output logic   busy,
    output logic   frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(SCALE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    seq_state_e       state;
    seq_state_e       state_next;
    logic [COL_W-1:0] col;
    logic [REP_W-1:0] hrep;
    logic [REP_W-1:0] vrep;
    logic [ROW_W-1:0] row;
    logic             buf_we;
    logic             buf_re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Writes happen only in FILL and reads only in EMIT, so the port is never shared.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        buf_we     = 1'b0;
        buf_re     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !busy) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                s_ready = 1'b1;
                buf_we  = s_valid;
                if (s_valid && col == COL_LAST) begin
                    state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                buf_re = 1'b1;
                if (col == COL_LAST && hrep == REP_LAST) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (vrep != REP_LAST) begin
                    state_next = S_EMIT;
                end else if (row != ROW_LAST) begin
                    state_next = S_FILL;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            hrep <= '0;
            vrep <= '0;
            row  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    col  <= '0;
                    hrep <= '0;
                    vrep <= '0;
                    row  <= '0;
                end
                S_FILL: begin
                    if (s_valid) begin
                        col <= (col == COL_LAST) ? '0 : col + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (hrep == REP_LAST) begin
                        hrep <= '0;
                        col  <= (col == COL_LAST) ? '0 : col + 1'b1;
                    end else begin
                        hrep <= hrep + 1'b1;
                    end
                end
                S_GAP: begin
                    if (vrep != REP_LAST) begin
                        vrep <= vrep + 1'b1;
                    end else if (row != ROW_LAST) begin
                        row  <= row + 1'b1;
                        vrep <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    line_buffer_sp #(
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .re    (buf_re),
        .addr  (col),
        .wdata (s_pixel),
        .rdata (m_pixel)
    );

    // busy stays up through the frame_done cycle so a start coinciding with it is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            m_valid    <= buf_re;
            frame_done <= (state == S_GAP) && (state_next == S_IDLE);
            if (state == S_IDLE && start && !busy) begin
                busy <= 1'b1;
            end else if (frame_done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_upscale_sequencer.sv
// tb/tb_upscale_sequencer.sv - self-checking bench for upscale_sequencer against a replication model
module tb_upscale_sequencer;
    import upscaler_pkg::*;

    localparam int W  = 6;
    localparam int H  = 3;
    localparam int S  = 3;
    localparam int W1 = 4;
    localparam int H1 = 2;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   start, s_valid, s_ready, m_valid, busy, frame_done;
    pixel_t s_pixel, m_pixel;
    logic   start1, s_valid1, s_ready1, m_valid1, busy1, frame_done1;
    pixel_t s_pixel1, m_pixel1;

    always #5 clk = ~clk;

    upscale_sequencer #(.IMG_W(W), .IMG_H(H), .SCALE(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_pixel(s_pixel), .s_valid(s_valid),
        .s_ready(s_ready), .m_pixel(m_pixel), .m_valid(m_valid), .busy(busy), .frame_done(frame_done)
    );

    upscale_sequencer #(.IMG_W(W1), .IMG_H(H1), .SCALE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .s_pixel(s_pixel1), .s_valid(s_valid1),
        .s_ready(s_ready1), .m_pixel(m_pixel1), .m_valid(m_valid1), .busy(busy1), .frame_done(frame_done1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Passive monitors: they only accumulate, the test tasks diff snapshots.
    int     cyc = 0;
    pixel_t got_q [$];
    int     rise_q [$];
    int     gap_cnt = 0, bad_run = 0, run = 0, sready_bad = 0, done_cnt = 0;
    logic   prev_mv = 1'b0;
    pixel_t got1_q [$];
    int     gap1 = 0, bad_run1 = 0, run1 = 0;
    logic   prev_mv1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            got_q.push_back(m_pixel);
            run <= run + 1;
            if (!prev_mv) rise_q.push_back(cyc);
        end else if (prev_mv) begin
            gap_cnt <= gap_cnt + 1;
            if (run != W * S) bad_run <= bad_run + 1;
            run <= 0;
        end
        if (m_valid === 1'b1 && s_ready === 1'b1) sready_bad <= sready_bad + 1;
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        prev_mv <= (m_valid === 1'b1);
    end

    always @(negedge clk) begin
        if (m_valid1 === 1'b1) begin
            got1_q.push_back(m_pixel1);
            run1 <= run1 + 1;
        end else if (prev_mv1) begin
            gap1 <= gap1 + 1;
            if (run1 != W1) bad_run1 <= bad_run1 + 1;
            run1 <= 0;
        end
        prev_mv1 <= (m_valid1 === 1'b1);
    end

    typedef struct {
        int stall_pct;
        bit poke;
        bit ramp;
        int exp_valid;
        int exp_gaps;
    } scen_t;

    scen_t tbl [5];

    task automatic run_frame(input int idx, input scen_t sc);
        pixel_t frame [W*H];
        pixel_t exp_q [$];
        int q0, r0, g0, b0, d0, sb0, k, guard, last_fill, bad, lat;
        bit fire, poked, done_seen;
        for (int i = 0; i < W * H; i++) frame[i] = sc.ramp ? pixel_t'(i + 1) : pixel_t'($urandom);
        for (int r = 0; r < H; r++)
            for (int v = 0; v < S; v++)
                for (int c = 0; c < W; c++)
                    for (int h = 0; h < S; h++) exp_q.push_back(frame[r * W + c]);
        q0 = got_q.size(); r0 = rise_q.size(); g0 = gap_cnt; b0 = bad_run; d0 = done_cnt; sb0 = sready_bad;
        last_fill = -100; poked = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0; guard = 0;
        while (k < W * H && guard < 4000) begin
            s_pixel = frame[k];
            s_valid = ($urandom_range(0, 99) >= sc.stall_pct);
            fire = s_valid && s_ready;
            if (fire) begin
                if (k == W - 1) last_fill = cyc;
                k++;
            end
            if (sc.poke && !poked && m_valid) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        s_valid = 1'b0; start = 1'b0;
        check($sformatf("s%0d_inputs_taken", idx), k, W * H);
        guard = 0; done_seen = 1'b0;
        while (!done_seen && guard < 4000) begin
            if (frame_done) begin
                done_seen = 1'b1;
                check($sformatf("s%0d_gap_at_done", idx), m_valid, 1'b0);
                check($sformatf("s%0d_busy_at_done", idx), busy, 1'b1);
            end else begin
                guard++;
                @(negedge clk);
            end
        end
        check($sformatf("s%0d_frame_done_seen", idx), done_seen, 1'b1);
        @(negedge clk);
        check($sformatf("s%0d_busy_after_done", idx), busy, 1'b0);
        check($sformatf("s%0d_pixel_known", idx), $isunknown(m_pixel), 1'b0);
        check($sformatf("s%0d_valid_count", idx), got_q.size() - q0, sc.exp_valid);
        check($sformatf("s%0d_gap_count", idx), gap_cnt - g0, sc.exp_gaps);
        check($sformatf("s%0d_row_run_len", idx), bad_run - b0, 0);
        check($sformatf("s%0d_sready_in_emit", idx), sready_bad - sb0, 0);
        check($sformatf("s%0d_done_pulses", idx), done_cnt - d0, 1);
        lat = (rise_q.size() > r0) ? rise_q[r0] - last_fill : -1;
        check($sformatf("s%0d_first_valid_latency", idx), lat, 2);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (q0 + i >= got_q.size() || got_q[q0 + i] !== exp_q[i]) bad++;
        check($sformatf("s%0d_stream_mismatches", idx), bad, 0);
    endtask

    task automatic run_scale1();
        pixel_t in1 [W1*H1];
        int n0, g0, b0, k, guard, bad;
        for (int i = 0; i < W1 * H1; i++) in1[i] = pixel_t'($urandom);
        n0 = got1_q.size(); g0 = gap1; b0 = bad_run1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        k = 0; guard = 0;
        while (k < W1 * H1 && guard < 500) begin
            s_pixel1 = in1[k];
            s_valid1 = 1'b1;
            if (s_ready1) k++;
            guard++;
            @(negedge clk);
        end
        s_valid1 = 1'b0;
        guard = 0;
        while (!frame_done1 && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check("x1_frame_done_seen", frame_done1, 1'b1);
        @(negedge clk);
        check("x1_busy_after_done", busy1, 1'b0);
        check("x1_valid_count", got1_q.size() - n0, W1 * H1);
        check("x1_gap_count", gap1 - g0, H1);
        check("x1_row_run_len", bad_run1 - b0, 0);
        bad = 0;
        for (int i = 0; i < W1 * H1; i++)
            if (n0 + i >= got1_q.size() || got1_q[n0 + i] !== in1[i]) bad++;
        check("x1_stream_mismatches", bad, 0);
    endtask

    task automatic reset_mid_emit();
        int guard;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < W; i++) begin
            s_pixel = pixel_t'($urandom);
            s_valid = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        guard = 0;
        while (!m_valid && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        check("rst_pre_m_valid", m_valid, 1'b1);
        check("rst_pre_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_m_valid", m_valid, 1'b0);
        check("rst_async_s_ready", s_ready, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_m_pixel", m_pixel, 24'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; s_valid = 1'b0; s_pixel = '0;
        start1 = 1'b0; s_valid1 = 1'b0; s_pixel1 = '0;
        tbl[0] = '{stall_pct: 0,  poke: 1'b0, ramp: 1'b1, exp_valid: W*H*S*S, exp_gaps: H*S};
        tbl[1] = '{stall_pct: 50, poke: 1'b0, ramp: 1'b1, exp_valid: W*H*S*S, exp_gaps: H*S};
        tbl[2] = '{stall_pct: 50, poke: 1'b1, ramp: 1'b0, exp_valid: W*H*S*S, exp_gaps: H*S};
        tbl[3] = '{stall_pct: 0,  poke: 1'b1, ramp: 1'b0, exp_valid: W*H*S*S, exp_gaps: H*S};
        tbl[4] = '{stall_pct: 25, poke: 1'b0, ramp: 1'b0, exp_valid: W*H*S*S, exp_gaps: H*S};
        #12;
        check("reset_s_ready", s_ready, 1'b0);
        check("reset_m_valid", m_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_m_pixel", m_pixel, 24'h0);
        check("reset_x1_m_pixel", m_pixel1, 24'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) run_frame(i, tbl[i]);
        reset_mid_emit();
        run_frame(5, tbl[4]);
        run_scale1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
